// File: rtl/pila_retorno.sv
// Hardware return-address stack (LIFO) with combinational top-of-stack read.
// Define PILA_GUARD_EN for full/empty protection and sticky overflow/underflow flags.
module pila_retorno #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PW:0]   CntFull = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CntOne  = (PW+1)'(1);
  localparam logic [PW-1:0] PtrOne  = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // ptr_q is the next free slot modulo DEPTH; it tracks count_q except after
  // an unguarded wrap, where count_q saturates but ptr_q keeps circulating.
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [PW:0]      count_q, count_d;
  logic             we;
  logic [PW-1:0]    waddr;
  logic             ovf_set, udf_set;

  assign top_idx = ptr_q - PtrOne;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[top_idx];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = ptr_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        we    = 1'b1;
        waddr = top_idx;
      end else begin
        we      = 1'b1;
        ptr_d   = ptr_q + PtrOne;
        count_d = count_q + CntOne;
        udf_set = 1'b1;
      end
    end else if (push) begin
      if (full) begin
        ovf_set = 1'b1;
`ifndef PILA_GUARD_EN
        // Unguarded: overwrite the oldest entry, count stays saturated.
        we    = 1'b1;
        ptr_d = ptr_q + PtrOne;
`endif
      end else begin
        we      = 1'b1;
        ptr_d   = ptr_q + PtrOne;
        count_d = count_q + CntOne;
      end
    end else if (pop) begin
      if (!empty) begin
        ptr_d   = ptr_q - PtrOne;
        count_d = count_q - CntOne;
      end else begin
        udf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not cleared on reset; dout is gated by empty.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem_q[waddr] <= din;
    end
  end

`ifdef PILA_GUARD_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | ovf_set;
    udf_d = udf_q | udf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_set ^ udf_set;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Scoreboard bench for pila_retorno: stimulus queues expected outputs, a monitor
// compares them at the falling edge. Expectations follow PILA_GUARD_EN if defined.
module tb_pila_retorno;

`ifdef PILA_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [9:0] din, dout;
  logic [4:0] count;
  logic       empty, full, overflow, underflow;

  typedef struct {
    string      name;
    logic [4:0] cnt;
    logic [9:0] dout;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pila_retorno #(.WIDTH(10), .DEPTH(16), .PW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .dout     (dout),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Monitor: compare all outputs against the expectation for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic exp_empty, exp_full;
      e         = sb.pop_front();
      exp_empty = (e.cnt == 5'd0);
      exp_full  = (e.cnt == 5'd16);
      checks++;
      if (count !== e.cnt || dout !== e.dout || empty !== exp_empty || full !== exp_full ||
          overflow !== e.ovf || underflow !== e.udf) begin
        errors++;
        $display("FAIL %s: got cnt=%0d dout=%h emp=%b full=%b ovf=%b udf=%b, want cnt=%0d dout=%h emp=%b full=%b ovf=%b udf=%b",
                 e.name, count, dout, empty, full, overflow, underflow,
                 e.cnt, e.dout, exp_empty, exp_full, e.ovf, e.udf);
      end
    end
  end

  task automatic drive(input logic r, input logic p, input logic q, input logic [9:0] d);
    @(posedge clk);
    #1;
    reset = r;
    push  = p;
    pop   = q;
    din   = d;
  endtask

  task automatic expect_now(input string n, input logic [4:0] c, input logic [9:0] d,
                            input logic o, input logic u);
    exp_t e;
    e.name = n;
    e.cnt  = c;
    e.dout = d;
    e.ovf  = o;
    e.udf  = u;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;

    // Basic push/pop
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);         expect_now("reset_state", 0, 0, 0, 0);
    drive(0, 1, 0, 10'h005);   expect_now("push1_cycle", 0, 0, 0, 0);
    drive(0, 1, 0, 10'h012);   expect_now("push2_cycle", 1, 10'h005, 0, 0);
    drive(0, 0, 1, 0);         expect_now("pop_cycle", 2, 10'h012, 0, 0);
    drive(0, 0, 0, 0);         expect_now("after_pop", 1, 10'h005, 0, 0);

    // Underflow
    drive(0, 0, 1, 0);         expect_now("pop_last", 1, 10'h005, 0, 0);
    drive(0, 0, 1, 0);         expect_now("pop_empty_cycle", 0, 0, 0, 0);
    drive(0, 0, 0, 0);         expect_now("underflow_set", 0, 0, 0, G);
    drive(0, 1, 0, 10'h033);   expect_now("push_after_udf", 0, 0, 0, G);
    drive(0, 0, 0, 0);         expect_now("udf_sticky", 1, 10'h033, 0, G);

    // Fill, overflow attempt, drain
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) drive(0, 1, 0, 10'(i));
    drive(0, 0, 0, 0);         expect_now("full16", 16, 10'd16, 0, 0);
    drive(0, 1, 0, 10'h3FF);   expect_now("push_full_cycle", 16, 10'd16, 0, 0);
    drive(0, 0, 0, 0);         expect_now("after_push_full", 16, G ? 10'd16 : 10'h3FF, G, 0);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 0);
      expect_now("drain", 5'(16 - k), G ? 10'(16 - k) : (k == 0 ? 10'h3FF : 10'(17 - k)), G, 0);
    end
    drive(0, 0, 0, 0);         expect_now("drained", 0, 0, G, 0);

    // Replace top
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 10'd7);
    drive(0, 1, 0, 10'd9);
    drive(0, 1, 1, 10'h0AA);   expect_now("replace_cycle", 2, 10'd9, 0, 0);
    drive(0, 0, 0, 0);         expect_now("replaced", 2, 10'h0AA, 0, 0);
    drive(0, 0, 1, 0);         expect_now("pop_replaced", 2, 10'h0AA, 0, 0);
    drive(0, 0, 0, 0);         expect_now("below_replaced", 1, 10'd7, 0, 0);

    // Push+pop on empty performs the push and flags underflow
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 10'h044);   expect_now("pp_empty_cycle", 0, 0, 0, 0);
    drive(0, 0, 0, 0);         expect_now("pp_empty_after", 1, 10'h044, 0, G);

    // Reset beats a simultaneous push and clears the flags
    drive(0, 1, 0, 10'd1);
    drive(0, 1, 0, 10'd2);
    drive(0, 1, 0, 10'd3);     expect_now("pre_reset", 3, 10'd2, 0, G);
    drive(1, 1, 0, 10'h111);   expect_now("reset_push_cycle", 4, 10'd3, 0, G);
    drive(0, 0, 0, 0);         expect_now("reset_won", 0, 0, 0, 0);

    // 17 pushes
    for (int i = 1; i <= 17; i++) drive(0, 1, 0, 10'(i));
    drive(0, 0, 0, 0);         expect_now("push17", 16, G ? 10'd16 : 10'd17, G, 0);
    drive(0, 1, 1, 10'h2AA);   expect_now("pp_full_cycle", 16, G ? 10'd16 : 10'd17, G, 0);
    drive(0, 0, 0, 0);         expect_now("pp_full_after", 16, 10'h2AA, G, 0);

    begin
      int budget = 100;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_scoreboard: got %0d pending, want 0", sb.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pila_retorno.md
Name: pila_retorno

Overview:
- Hardware return-address stack (LIFO). It is the responder to the control unit's push / pop / s_pila signals.
- On push it stores the return address supplied by the datapath (PC+1).
- On pop it presents the saved address on dout. The datapath's s_pila mux loads dout into PC at the same clock edge.
- Sits beside the PC register. Single clock domain.

Parameters:
- WIDTH, 10, address width in bits; matches the PC width.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- PW, 4, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  store din on top of stack this cycle.
- pop  input  1  remove top of stack this cycle.
- din  input  WIDTH  return address to store (PC+1 from the datapath).
- dout  output  WIDTH  current top-of-stack; combinational read.
- count  output  PW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage: mem[0..DEPTH-1]. Stack pointer sp (PW+1 bits) = count; it points at the next free slot.
- Reset (sync, reset=1 at the clock edge):
  - sp=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Resulting outputs: dout=0, empty=1, full=0, count=0.
  - Reset wins over push/pop in the same cycle; any in-flight operation is discarded.
- dout:
  - dout = mem[sp-1] when sp>0, else 0.
  - Purely combinational, zero latency, so the PC mux captures it at the same edge on which pop takes effect.
- Push only (push=1, pop=0):
  - If not full: mem[sp] <= din, sp <= sp+1. The new top is visible on dout the next cycle.
  - If full: no write, sp unchanged, overflow <= 1.
- Pop only (push=0, pop=1):
  - If not empty: sp <= sp-1. dout during the pop cycle is the popped value.
  - If empty: sp unchanged, underflow <= 1, dout=0.
- Push and pop together:
  - If not empty: replace the top. mem[sp-1] <= din, sp unchanged, dout shows the old top during the cycle. Never flags overflow, even when full.
  - If empty: underflow <= 1 and the push is performed (mem[0] <= din, sp <= 1).
- Neither asserted: hold all state.
- Sticky flags: overflow and underflow clear only on reset.
- Reads of unwritten entries are impossible, because dout is gated by sp>0.

Optional Feature:
- Macro: PILA_GUARD_EN.
- Defined: the full/empty protection, overflow and underflow flags behave exactly as above.
- Undefined: no guarding.
  - Push when full writes mem[sp mod DEPTH] and sp wraps to 1 (oldest entry lost). Count saturates at DEPTH and full stays set.
  - Pop when empty leaves sp at 0.
  - overflow and underflow are tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset, then push din=10'h005, then 10'h012 → count=2, dout=10'h012. Pop → dout=10'h012 during the pop cycle; next cycle dout=10'h005, count=1.
- Pop with empty=1 → underflow=1, count=0, dout=0. A later push of 10'h033 → count=1, dout=10'h033, underflow still 1.
- Push 16 values 1..16 → full=1, dout=16. Push 10'h3FF → overflow=1 (GUARD on), dout=16. Pop 16 times → values seen in order 16..1, then empty=1.
- Stack holds 7,9; push=pop=1 with din=10'h0AA → dout=9 that cycle; next cycle dout=10'h0AA, count=2. Pop → dout=7 next.
- Push 3 entries, then assert reset together with push=1 din=10'h111 → next cycle count=0, empty=1, dout=0, both flags 0.
- Build without PILA_GUARD_EN: push 17 values 1..17 → overflow=0, count=16, dout=17.
